moka_rv32i_sc_trace_tx: RTL and testbench

MOKA_RV32I_SC_TRACE_TX -- requirements
Module: moka_rv32i_sc_trace_tx

---
 rtl/moka_rv32i_sc_trace_tx.sv | 148 ++++++++++++++
 tb/tb_moka_rv32i_sc_trace_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/moka_rv32i_sc_trace_tx.sv
// Retirement trace transmitter for a single-cycle RV32I core.
// Each retired instruction is captured as a four-word record
// (header, pc, instruction, payload) into a small record FIFO, and a
// serializer streams the head record out one word per handshake.
// Optional build macro: MOKA_TRACE_STALL_EN adds a core stall request
// when the record FIFO is full and cannot free a slot this cycle.
//
// tx handshake: a word transfers on a rising edge where tx_valid and
// tx_ready are both high; tx_valid never depends on tx_ready, and
// tx_data/tx_last stay stable while tx_valid=1 and tx_ready=0.
module moka_rv32i_sc_trace_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  retire_valid,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic [4:0]            rd,
  input  logic                  RegWrite,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] RD2,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  output logic                  core_stall,
  output logic [15:0]           drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_PC    = 2'd1,
    ST_INSTR = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  // Record storage, one array per word slot of a record
  logic [DATA_WIDTH-1:0] hdr_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem  [DEPTH];

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [15:0]           seq;
  logic                  ovf_pending;
  state_t                state;

  logic                  full;
  logic                  handshake;
  logic                  pop;
  logic                  accept;
  logic                  drop;
  logic [DATA_WIDTH-1:0] header;
  logic [DATA_WIDTH-1:0] payload;

  assign full      = (count == CW'(DEPTH));
  assign tx_valid  = (count != '0);
  assign handshake = tx_valid && tx_ready;
  assign pop       = handshake && (state == ST_DATA);
  // A full FIFO still takes a record if the head leaves on the same edge
  assign accept    = retire_valid && (!full || pop);
  assign drop      = retire_valid && !accept;

  assign header  = {seq, ovf_pending, RegWrite, MemWrite, rd, 8'hA5};
  assign payload = RegWrite ? WD3 : (MemWrite ? RD2 : ALUResult);

  // Select the head record's word for the current serializer position
  always_comb begin
    tx_data = '0;
    if (tx_valid) begin
      case (state)
        ST_HDR:   tx_data = hdr_mem[rd_ptr];
        ST_PC:    tx_data = pc_mem[rd_ptr];
        ST_INSTR: tx_data = instr_mem[rd_ptr];
        default:  tx_data = data_mem[rd_ptr];
      endcase
    end
  end

  assign tx_last = tx_valid && (state == ST_DATA);

`ifdef MOKA_TRACE_STALL_EN
  assign core_stall = full && !((state == ST_DATA) && tx_ready);
`else
  assign core_stall = 1'b0;
`endif

  // Write an accepted record into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      hdr_mem[wr_ptr]   <= header;
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= instruction;
      data_mem[wr_ptr]  <= payload;
    end
  end

  // Serializer FSM, FIFO bookkeeping, sequence and drop tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_HDR;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      seq         <= '0;
      ovf_pending <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (handshake) begin
        case (state)
          ST_HDR:   state <= ST_PC;
          ST_PC:    state <= ST_INSTR;
          ST_INSTR: state <= ST_DATA;
          default:  state <= ST_HDR;
        endcase
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept) begin
        wr_ptr      <= wr_ptr + 1'b1;
        seq         <= seq + 1'b1;
        ovf_pending <= 1'b0;
      end
      if (drop) begin
        ovf_pending <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_moka_rv32i_sc_trace_tx.sv
// Bench for moka_rv32i_sc_trace_tx: the expected output is a flat queue of
// trace words (four per accepted record); a per-cycle compare process
// checks the DUT against it, and directed sequences pin literal values.
module tb_moka_rv32i_sc_trace_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          retire_valid;
  logic [DW-1:0] pc;
  logic [DW-1:0] instruction;
  logic [4:0]    rd;
  logic          RegWrite;
  logic          MemWrite;
  logic [DW-1:0] WD3;
  logic [DW-1:0] ALUResult;
  logic [DW-1:0] RD2;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_last;
  logic          core_stall;
  logic [15:0]   drop_cnt;

  moka_rv32i_sc_trace_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire_valid (retire_valid),
    .pc           (pc),
    .instruction  (instruction),
    .rd           (rd),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .WD3          (WD3),
    .ALUResult    (ALUResult),
    .RD2          (RD2),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .core_stall   (core_stall),
    .drop_cnt     (drop_cnt)
  );

  // Clock and counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  bit chk_en;

  // Scoreboard state: words still to be sent, in order
  logic [DW-1:0] exp_q[$];
  logic [15:0]   m_seq;
  logic          m_ovf;
  logic [15:0]   m_drop;
  int            m_recs;
  bit            m_hs;
  bit            m_pop_last;
  logic [DW-1:0] m_payload;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance the word stream on each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_seq  = '0;
      m_ovf  = 1'b0;
      m_drop = '0;
    end else begin
      m_recs     = (exp_q.size() + 3) / 4;
      m_hs       = (exp_q.size() != 0) && tx_ready;
      m_pop_last = m_hs && (exp_q.size() % 4 == 1);
      if (m_hs) void'(exp_q.pop_front());
      if (retire_valid) begin
        if (m_recs < DEPTH || m_pop_last) begin
          m_payload = RegWrite ? WD3 : (MemWrite ? RD2 : ALUResult);
          exp_q.push_back({m_seq, m_ovf, RegWrite, MemWrite, rd, 8'hA5});
          exp_q.push_back(pc);
          exp_q.push_back(instruction);
          exp_q.push_back(m_payload);
          m_seq = m_seq + 16'd1;
          m_ovf = 1'b0;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_valid", {31'd0, tx_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
      check("tx_last", {31'd0, tx_last},
            {31'd0, (exp_q.size() % 4 == 1)});
      check("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});
`ifdef MOKA_TRACE_STALL_EN
      check("core_stall", {31'd0, core_stall},
            {31'd0, ((exp_q.size() + 3) / 4 == DEPTH) &&
                    !(tx_ready && (exp_q.size() % 4 == 1))});
`else
      check("core_stall", {31'd0, core_stall}, 32'd0);
`endif
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_retire(input logic [DW-1:0] a_pc, input logic [DW-1:0] a_ins,
                            input logic [4:0] a_rd, input logic a_rw,
                            input logic a_mw, input logic [DW-1:0] a_wd3,
                            input logic [DW-1:0] a_alu, input logic [DW-1:0] a_rd2);
    pc = a_pc; instruction = a_ins; rd = a_rd; RegWrite = a_rw;
    MemWrite = a_mw; WD3 = a_wd3; ALUResult = a_alu; RD2 = a_rd2;
    retire_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; chk_en = 1'b0;
    rst_n = 1'b0; retire_valid = 1'b0; tx_ready = 1'b0;
    pc = '0; instruction = '0; rd = '0; RegWrite = 1'b0; MemWrite = 1'b0;
    WD3 = '0; ALUResult = '0; RD2 = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Reset state
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_last",  {31'd0, tx_last}, 32'd0);
    check("rst_data",  tx_data, 32'd0);
    check("rst_stall", {31'd0, core_stall}, 32'd0);
    check("rst_drop",  {16'd0, drop_cnt}, 32'd0);

    // Single register-write capture
    tx_ready = 1'b1;
    set_retire(32'h100, 32'h00500093, 5'd1, 1'b1, 1'b0, 32'h5, 32'h105, 32'h77);
    tick(); retire_valid = 1'b0;
    check("cap_hdr", tx_data, 32'h0000_41A5);
    check("cap_hdr_last", {31'd0, tx_last}, 32'd0);
    tick(); check("cap_pc", tx_data, 32'h100);
    tick(); check("cap_instr", tx_data, 32'h00500093);
    tick(); check("cap_data", tx_data, 32'h5);
    check("cap_data_last", {31'd0, tx_last}, 32'd1);
    tick(); check("cap_idle", {31'd0, tx_valid}, 32'd0);

    // Store payload
    set_retire(32'h104, 32'h0020a023, 5'd3, 1'b0, 1'b1, 32'h1234, 32'h40, 32'hDEADBEEF);
    tick(); retire_valid = 1'b0;
    check("st_hdr", tx_data, 32'h0001_23A5);
    check("st_flags", {29'd0, tx_data[15:13]}, 32'd1);
    repeat (3) tick();
    check("st_data", tx_data, 32'hDEADBEEF);
    tick();

    // Backpressure mid-record
    set_retire(32'h108, 32'h00000013, 5'd0, 1'b0, 1'b0, 32'h0, 32'hABC, 32'h0);
    tick(); retire_valid = 1'b0;
    check("bp_hdr", tx_data, 32'h0002_00A5);
    tick(); check("bp_pc", tx_data, 32'h108);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", tx_data, 32'h108);
      check("bp_hold_last", {31'd0, tx_last}, 32'd0);
    end
    tx_ready = 1'b1;
    tick(); check("bp_instr", tx_data, 32'h13);
    tick(); check("bp_data", tx_data, 32'hABC);
    tick(); check("bp_idle", {31'd0, tx_valid}, 32'd0);

    // Overflow: six back-to-back retires into a blocked FIFO
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_retire(32'h200 + 32'(4 * i), 32'h13, 5'(i + 1), 1'b1, 1'b0, 32'(i), 32'h0, 32'h0);
      tick();
    end
    retire_valid = 1'b0;
    check("ovf_drop", {16'd0, drop_cnt}, 32'd2);
    check("ovf_head", tx_data, 32'h0000_41A5);
    tx_ready = 1'b1;
    repeat (17) tick();
    check("ovf_drained", {31'd0, tx_valid}, 32'd0);
    set_retire(32'h300, 32'h13, 5'd2, 1'b1, 1'b0, 32'h9, 32'h0, 32'h0);
    tick(); retire_valid = 1'b0;
    check("ovf_next_hdr", tx_data, 32'h0004_C2A5);
    check("ovf_drop_kept", {16'd0, drop_cnt}, 32'd2);
    repeat (4) tick();

`ifdef MOKA_TRACE_STALL_EN
    // Stall request while full, released in the DATA handshake cycle
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_retire(32'h600 + 32'(4 * i), 32'h13, 5'd7, 1'b0, 1'b0, 32'h0, 32'(i), 32'h0);
      tick();
    end
    retire_valid = 1'b0;
    #1 check("stall_full", {31'd0, core_stall}, 32'd1);
    tx_ready = 1'b1;
    #1 check("stall_hdr", {31'd0, core_stall}, 32'd1);
    repeat (3) tick();
    #1 check("stall_release", {31'd0, core_stall}, 32'd0);
    check("stall_last", {31'd0, tx_last}, 32'd1);
    check("stall_drop", {16'd0, drop_cnt}, 32'd0);
    repeat (13) tick();
`endif

    // Reset mid-record after the PC word
    do_reset();
    tx_ready = 1'b1;
    set_retire(32'h400, 32'h13, 5'd0, 1'b0, 1'b0, 32'h0, 32'h1, 32'h0);
    tick(); retire_valid = 1'b0;
    tick(); check("mr_pc", tx_data, 32'h400);
    tick();
    rst_n = 1'b0;
    set_retire(32'h444, 32'h13, 5'd9, 1'b1, 1'b0, 32'h1, 32'h0, 32'h0);
    tick();
    check("mr_valid", {31'd0, tx_valid}, 32'd0);
    check("mr_last", {31'd0, tx_last}, 32'd0);
    rst_n = 1'b1; retire_valid = 1'b0;
    tick();
    check("mr_idle", {31'd0, tx_valid}, 32'd0);
    set_retire(32'h500, 32'h13, 5'd5, 1'b1, 1'b0, 32'h3, 32'h0, 32'h0);
    tick(); retire_valid = 1'b0;
    check("mr_new_hdr", tx_data, 32'h0000_45A5);
    repeat (4) tick();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      retire_valid = $urandom_range(0, 1) == 1;
      tx_ready     = $urandom_range(0, 9) < 6;
      pc           = $urandom;
      instruction  = $urandom;
      rd           = 5'($urandom_range(0, 31));
      RegWrite     = $urandom_range(0, 1) == 1;
      MemWrite     = $urandom_range(0, 1) == 1;
      WD3          = $urandom;
      ALUResult    = $urandom;
      RD2          = $urandom;
      tick();
    end

    rst_n = 1'b1; retire_valid = 1'b0; tx_ready = 1'b1;
    repeat (20) tick();
    check("end_idle", {31'd0, tx_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
